// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data memory access (MEM) and MEM/WB pipeline register.
// Drives register-file write-back and exports MEM-stage dest for hazards.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   freeze        hold MEM/WB register, suppress memory write
//   wbEn_in       instruction writes a register
//   memREn_in     load
//   memWEn_in     store
//   aluRes_in     ALU result / effective byte address
//   valRm_in      store data
//   dest_in       destination register
//   memDest       dest_in passthrough (hazard unit)
//   memWbEn       wbEn_in passthrough (hazard unit)
//   wbValue       write-back data
//   wbDest        write-back register index
//   wbEn          write-back enable
//   memErr        sticky out-of-range access flag
//
// Optional: define DMEM_RESET_CLEAR_EN to clear data memory on rst.

module mem_wb_stage #(
   parameter int unsigned DMEM_DEPTH = 64,
   parameter logic [31:0] DMEM_BASE  = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        wbEn_in,
   input  logic        memREn_in,
   input  logic        memWEn_in,
   input  logic [31:0] aluRes_in,
   input  logic [31:0] valRm_in,
   input  logic [3:0]  dest_in,
   output logic [3:0]  memDest,
   output logic        memWbEn,
   output logic [31:0] wbValue,
   output logic [3:0]  wbDest,
   output logic        wbEn,
   output logic        memErr
);

   localparam int IDX_W =
      (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   typedef struct packed {
      logic        wbEn;
      logic        memREn;
      logic [31:0] aluRes;
      logic [31:0] memData;
      logic [3:0]  dest;
   } memWb_t;

   logic [31:0]      mem [DMEM_DEPTH];
   logic [31:0]      offset;
   logic [29:0]      wordIdx;
   logic [IDX_W-1:0] memIdx;
   logic             inRange;
   logic             access;
   logic             doWrite;
   logic [31:0]      memData;
   memWb_t           wbReg;

   // Wrapping subtraction: addresses below the base give a huge
   // index, but the explicit base compare rejects them anyway.
   assign offset  = aluRes_in - DMEM_BASE;
   assign wordIdx = 30'(offset >> 2);
   assign memIdx  = wordIdx[IDX_W-1:0];
   assign inRange = (aluRes_in >= DMEM_BASE)
                 && (wordIdx < 30'(DMEM_DEPTH));

   assign access  = memREn_in | memWEn_in;
   assign doWrite = memWEn_in & ~freeze & inRange;

   // Read is combinational, so a simultaneous read+write
   // naturally returns the pre-write word.
   assign memData = inRange ? mem[memIdx] : '0;

`ifdef DMEM_RESET_CLEAR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (doWrite) begin
         mem[memIdx] <= valRm_in;
      end
   end
`else
   // Contents persist across reset; a store coinciding
   // with rst is still dropped.
   always_ff @(posedge clk) begin
      if (!rst && doWrite) begin
         mem[memIdx] <= valRm_in;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbReg <= '0;
      end else if (!freeze) begin
         wbReg.wbEn    <= wbEn_in;
         wbReg.memREn  <= memREn_in;
         wbReg.aluRes  <= aluRes_in;
         wbReg.memData <= memData;
         wbReg.dest    <= dest_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memErr <= 1'b0;
      end else if (access && !freeze && !inRange) begin
         memErr <= 1'b1;
      end
   end

   assign wbValue = wbReg.memREn ? wbReg.memData
                                 : wbReg.aluRes;
   assign wbDest  = wbReg.dest;
   assign wbEn    = wbReg.wbEn;

   assign memDest = dest_in;
   assign memWbEn = wbEn_in;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed + random check of mem_wb_stage
// against a word-array reference model.

module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        wbEn_in = 1'b0;
   logic        memREn_in = 1'b0;
   logic        memWEn_in = 1'b0;
   logic [31:0] aluRes_in = '0;
   logic [31:0] valRm_in = '0;
   logic [3:0]  dest_in = '0;
   logic [3:0]  memDest;
   logic        memWbEn;
   logic [31:0] wbValue;
   logic [3:0]  wbDest;
   logic        wbEn;
   logic        memErr;

   int errors = 0;
   int checks = 0;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .freeze(freeze),
      .wbEn_in(wbEn_in), .memREn_in(memREn_in),
      .memWEn_in(memWEn_in), .aluRes_in(aluRes_in),
      .valRm_in(valRm_in), .dest_in(dest_in),
      .memDest(memDest), .memWbEn(memWbEn),
      .wbValue(wbValue), .wbDest(wbDest),
      .wbEn(wbEn), .memErr(memErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain word array plus expected outputs.
   logic [31:0] mdl   [64];
   bit          known [64];
   logic [31:0] eV;
   logic [3:0]  eD;
   logic        eE;
   logic        eErr;
   bit          eKnown;
   bit          started = 0;

   function automatic bit mapAddr(input logic [31:0] a,
                                  output int idx);
      longint unsigned ua;
      ua = a;
      idx = 0;
      if (ua < 1024) return 0;
      if ((ua - 1024) / 4 >= 64) return 0;
      idx = int'((ua - 1024) / 4);
      return 1;
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) known[i] = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            eV = 0; eD = 0; eE = 0; eErr = 0; eKnown = 1;
            started = 1;
`ifdef DMEM_RESET_CLEAR_EN
            for (int i = 0; i < 64; i++) begin
               mdl[i] = 0; known[i] = 1;
            end
`endif
         end else if (started && !freeze) begin
            int idx;
            bit ok;
            logic [31:0] rd;
            bit rdKnown;
            ok = mapAddr(aluRes_in, idx);
            rd = ok ? mdl[idx] : 32'h0;
            rdKnown = ok ? known[idx] : 1'b1;
            eV = memREn_in ? rd : aluRes_in;
            eKnown = memREn_in ? rdKnown : 1'b1;
            eD = dest_in;
            eE = wbEn_in;
            if (memWEn_in && ok) begin
               mdl[idx] = valRm_in; known[idx] = 1;
            end
            if ((memREn_in || memWEn_in) && !ok) eErr = 1;
         end
         #1;
         if (started) begin
            if (eKnown) chk("wbValue", wbValue, eV);
            chk("wbDest", 32'(wbDest), 32'(eD));
            chk("wbEn", 32'(wbEn), 32'(eE));
            chk("memErr", 32'(memErr), 32'(eErr));
            chk("memDest", 32'(memDest), 32'(dest_in));
            chk("memWbEn", 32'(memWbEn), 32'(wbEn_in));
         end
      end
   end

   task automatic drive(input logic we, input logic re,
                        input logic wb, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] ds,
                        input logic frz);
      @(negedge clk);
      memWEn_in = we; memREn_in = re; wbEn_in = wb;
      aluRes_in = a; valRm_in = d; dest_in = ds; freeze = frz;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #3 rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;

      for (int i = 0; i < 64; i++)
         drive(1, 0, 0, 32'(1024 + 4 * i),
               32'hA500_0000 | 32'(i), 4'd0, 0);

      // Reset mid-cycle clears outputs without a clock edge.
      drive(0, 0, 1, 32'd5, 0, 4'd3, 0);
      tick();
      chk("pre_rst_wbEn", 32'(wbEn), 32'd1);
      chk("pre_rst_wbValue", wbValue, 32'd5);
      @(negedge clk);
      #1 rst = 1;
      #1;
      chk("rst_wbValue", wbValue, 32'd0);
      chk("rst_wbDest", 32'(wbDest), 32'd0);
      chk("rst_wbEn", 32'(wbEn), 32'd0);
      chk("rst_memErr", 32'(memErr), 32'd0);
      @(negedge clk);
      rst = 0;

      // ALU result write-back.
      drive(0, 0, 1, 32'h2A, 0, 4'd3, 0);
      tick();
      chk("alu_wbValue", wbValue, 32'h2A);
      chk("alu_wbDest", 32'(wbDest), 32'd3);
      chk("alu_wbEn", 32'(wbEn), 32'd1);

      // Store then load to the same word.
      drive(1, 0, 0, 32'd1028, 32'hDEAD_BEEF, 4'd0, 0);
      drive(0, 1, 1, 32'd1028, 0, 4'd7, 0);
      tick();
      chk("ld_wbValue", wbValue, 32'hDEAD_BEEF);
      chk("ld_wbDest", 32'(wbDest), 32'd7);
      chk("ld_wbEn", 32'(wbEn), 32'd1);

      // Freeze holds outputs and blocks the store.
      drive(0, 0, 1, 32'h2A, 0, 4'd3, 0);
      tick();
      drive(1, 0, 1, 32'd1024, 32'h11, 4'd9, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("frz_wbValue", wbValue, 32'h2A);
         chk("frz_wbDest", 32'(wbDest), 32'd3);
         chk("frz_wbEn", 32'(wbEn), 32'd1);
      end
      drive(0, 1, 1, 32'd1024, 0, 4'd5, 0);
      tick();
      chk("frz_ld", wbValue, 32'hA500_0000);
      chk("frz_ld_dest", 32'(wbDest), 32'd5);

      // Out-of-range accesses.
      drive(1, 0, 0, 32'd1020, 32'h0BAD, 4'd0, 0);
      tick();
      chk("oor_err1", 32'(memErr), 32'd1);
      drive(0, 1, 1, 32'd1280, 0, 4'd2, 0);
      tick();
      chk("oor_ld", wbValue, 32'd0);
      chk("oor_err2", 32'(memErr), 32'd1);
      drive(0, 1, 1, 32'd1276, 0, 4'd2, 0);
      tick();
      chk("oor_w63", wbValue, 32'hA500_003F);
      drive(0, 1, 1, 32'd1024, 0, 4'd2, 0);
      tick();
      chk("oor_w0", wbValue, 32'hA500_0000);
      chk("oor_err3", 32'(memErr), 32'd1);

      // Memory contents across reset.
      drive(1, 0, 0, 32'd1032, 32'h55, 4'd0, 0);
      drive(0, 0, 0, 32'd0, 0, 4'd0, 0);
      #1 rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rc_memErr", 32'(memErr), 32'd0);
      drive(0, 1, 1, 32'd1032, 0, 4'd4, 0);
      tick();
`ifdef DMEM_RESET_CLEAR_EN
      chk("rc_ld", wbValue, 32'd0);
`else
      chk("rc_ld", wbValue, 32'h55);
`endif

      // Randomized traffic checked by the model each cycle.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         @(negedge clk);
         rst = 0;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = 32'(1000 + $urandom_range(0, 300));
         memWEn_in = ($urandom_range(0, 2) == 0);
         memREn_in = ($urandom_range(0, 2) == 0);
         wbEn_in   = 1'($urandom);
         aluRes_in = a;
         valRm_in  = $urandom;
         dest_in   = 4'($urandom);
         freeze    = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #1 rst = 1;
         end
      end
      @(negedge clk);
      rst = 0;
      freeze = 0;
      tick();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule
